// File: rtl/idex_pipe_stage.sv
// ---------------------------------------------------------------------------
// idex_pipe_stage
//
// ID/EX pipeline stage for the pipelined LEGv8 core. It carries the decoded
// instruction (control bundle, PC, operands, immediate, opcode and register
// indices) from decode/register-read into execute. The stage uses a
// valid/ready handshake, supports a flush that kills held instructions, and
// zeroes the control bundle whenever no instruction is presented, so a
// bubble can never write a register or memory. It also keeps a saturating
// count of back-pressured cycles.
//
// Build option (macro IDEX_SKID_EN):
//   defined   : main entry plus one skid entry. ready_out is a registered
//               signal (~skid valid), so there is no combinational path from
//               ready_in to ready_out.
//   undefined : single entry. ready_out = ~valid_out | ready_in
//               (combinational).
//
// Ports:
//   CLOCK, RESET              clock, synchronous active-high reset
//   valid_in / ready_out      decode-side handshake
//   flush                     discard all held instructions and the input
//   ctrl_in .. writeReg_in    decode-side instruction fields
//   valid_out / ready_in      execute-side handshake
//   ctrl_out .. writeReg_out  execute-side fields (ctrl_out zero when invalid)
//   stall_count               saturating count of cycles with
//                             valid_out & ~ready_in & ~flush
// ---------------------------------------------------------------------------
module idex_pipe_stage #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int OPC_W  = 11,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              flush,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] programCounter_in,
  input  logic [DATA_W-1:0] regData1_in,
  input  logic [DATA_W-1:0] regData2_in,
  input  logic [DATA_W-1:0] signExtend_in,
  input  logic [OPC_W-1:0]  ALUcontrol_in,
  input  logic [REG_W-1:0]  registerRm_in,
  input  logic [REG_W-1:0]  registerRn_in,
  input  logic [REG_W-1:0]  writeReg_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] programCounter_out,
  output logic [DATA_W-1:0] regData1_out,
  output logic [DATA_W-1:0] regData2_out,
  output logic [DATA_W-1:0] signExtend_out,
  output logic [OPC_W-1:0]  ALUcontrol_out,
  output logic [REG_W-1:0]  registerRm_out,
  output logic [REG_W-1:0]  registerRn_out,
  output logic [REG_W-1:0]  writeReg_out,
  output logic [CNT_W-1:0]  stall_count
);

  // One entry holds every field of an instruction, packed in port order.
  localparam int ENT_W = CTRL_W + 4*DATA_W + OPC_W + 3*REG_W;

  logic [ENT_W-1:0]  in_ent;
  logic [ENT_W-1:0]  main_q, main_d;
  logic              main_vld_q, main_vld_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CTRL_W-1:0] main_ctrl;
  logic              accept;
  logic              drain;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign in_ent = {ctrl_in, programCounter_in, regData1_in, regData2_in,
                   signExtend_in, ALUcontrol_in, registerRm_in,
                   registerRn_in, writeReg_in};

  assign accept = valid_in & ready_out;
  assign drain  = main_vld_q & ready_in;

`ifdef IDEX_SKID_EN
  logic [ENT_W-1:0] skid_q, skid_d;
  logic             skid_vld_q, skid_vld_d;

  // Only register state and RESET feed ready_out; ready_in never does.
  assign ready_out = ~skid_vld_q & ~RESET;

  // ---- decode -> main/skid entries ----
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    stall_d    = stall_q;
    if (flush) begin
      // Held instructions and the same-cycle input are all discarded;
      // data fields keep their last value.
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (main_vld_q && !ready_in) stall_d = sat_inc(stall_q);
      if (!main_vld_q || drain) begin
        // Main entry is free this cycle: the older skid entry wins over the
        // input to preserve order. A full skid implies ready_out=0, so the
        // two never compete.
        if (skid_vld_q) begin
          main_d     = skid_q;
          main_vld_d = 1'b1;
          skid_vld_d = 1'b0;
        end else begin
          main_vld_d = accept;
          if (accept) main_d = in_ent;
        end
      end else if (accept) begin
        skid_d     = in_ent;
        skid_vld_d = 1'b1;
      end
    end
  end

  // ---- state registers ----
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      stall_q    <= stall_d;
    end
  end
`else
  // Single entry: can take a new instruction when empty or when the held one
  // leaves this cycle.
  assign ready_out = (~main_vld_q | ready_in) & ~RESET;

  // ---- decode -> main entry ----
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    stall_d    = stall_q;
    if (flush) begin
      main_vld_d = 1'b0;
    end else begin
      if (main_vld_q && !ready_in) stall_d = sat_inc(stall_q);
      if (!main_vld_q || drain) begin
        main_vld_d = accept;
        if (accept) main_d = in_ent;
      end
    end
  end

  // ---- state registers ----
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      stall_q    <= stall_d;
    end
  end
`endif

  // ---- main entry -> execute ----
  assign {main_ctrl, programCounter_out, regData1_out, regData2_out,
          signExtend_out, ALUcontrol_out, registerRm_out, registerRn_out,
          writeReg_out} = main_q;

  // A bubble must never carry live control bits into execute.
  assign ctrl_out    = main_ctrl & {CTRL_W{main_vld_q}};
  assign valid_out   = main_vld_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_idex_pipe_stage.sv
module tb_idex_pipe_stage;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        valid_in;
  logic        flush;
  logic        ready_in;
  logic [7:0]  ctrl_in;
  logic [63:0] pc_in, rd1_in, rd2_in, sext_in;
  logic [10:0] aluc_in;
  logic [4:0]  rm_in, rn_in, wr_in;

  logic        ready_out, valid_out;
  logic [7:0]  ctrl_out;
  logic [63:0] pc_out, rd1_out, rd2_out, sext_out;
  logic [10:0] aluc_out;
  logic [4:0]  rm_out, rn_out, wr_out;
  logic [31:0] stall_count;

  // Second instance with a 4-bit counter, driven by the same inputs.
  logic        ready_out4, valid_out4;
  logic [7:0]  ctrl_out4;
  logic [63:0] pc_out4, rd1_out4, rd2_out4, sext_out4;
  logic [10:0] aluc_out4;
  logic [4:0]  rm_out4, rn_out4, wr_out4;
  logic [3:0]  stall_count4;

  int n_chk = 0;
  int n_fail = 0;

  idex_pipe_stage dut (
    .CLOCK(CLOCK), .RESET(RESET), .valid_in(valid_in), .ready_out(ready_out),
    .flush(flush), .ctrl_in(ctrl_in), .programCounter_in(pc_in),
    .regData1_in(rd1_in), .regData2_in(rd2_in), .signExtend_in(sext_in),
    .ALUcontrol_in(aluc_in), .registerRm_in(rm_in), .registerRn_in(rn_in),
    .writeReg_in(wr_in), .valid_out(valid_out), .ready_in(ready_in),
    .ctrl_out(ctrl_out), .programCounter_out(pc_out), .regData1_out(rd1_out),
    .regData2_out(rd2_out), .signExtend_out(sext_out),
    .ALUcontrol_out(aluc_out), .registerRm_out(rm_out),
    .registerRn_out(rn_out), .writeReg_out(wr_out),
    .stall_count(stall_count)
  );

  idex_pipe_stage #(.CNT_W(4)) dut4 (
    .CLOCK(CLOCK), .RESET(RESET), .valid_in(valid_in), .ready_out(ready_out4),
    .flush(flush), .ctrl_in(ctrl_in), .programCounter_in(pc_in),
    .regData1_in(rd1_in), .regData2_in(rd2_in), .signExtend_in(sext_in),
    .ALUcontrol_in(aluc_in), .registerRm_in(rm_in), .registerRn_in(rn_in),
    .writeReg_in(wr_in), .valid_out(valid_out4), .ready_in(ready_in),
    .ctrl_out(ctrl_out4), .programCounter_out(pc_out4),
    .regData1_out(rd1_out4), .regData2_out(rd2_out4),
    .signExtend_out(sext_out4), .ALUcontrol_out(aluc_out4),
    .registerRm_out(rm_out4), .registerRn_out(rn_out4),
    .writeReg_out(wr_out4), .stall_count(stall_count4)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (n_chk=%0d)", n_chk);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Other fields are simple functions of the PC so pass-through can be checked.
  task automatic set_in(input logic v, input logic [63:0] pc, input logic [7:0] c);
    valid_in = v;
    pc_in    = pc;
    ctrl_in  = c;
    rd1_in   = pc ^ 64'hFFFF_0000_FFFF_0000;
    rd2_in   = {pc[31:0], pc[63:32]};
    sext_in  = pc + 64'd8;
    aluc_in  = pc[10:0];
    rm_in    = pc[4:0] ^ 5'h1F;
    rn_in    = pc[6:2];
    wr_in    = pc[7:3];
  endtask

  task automatic reset_dut();
    RESET = 1'b1;
    flush = 1'b0;
    ready_in = 1'b0;
    set_in(1'b0, 64'h0, 8'h00);
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    flush = 1'b0;
    ready_in = 1'b1;
    set_in(1'b1, 64'h40, 8'hFF);
    step();
    step();
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    n_chk++; if (ctrl_out !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl got %h exp 00", ctrl_out); end
    n_chk++; if (pc_out !== 64'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc_out); end
    n_chk++; if (rd1_out !== 64'h0) begin n_fail++; $display("FAIL reset_rd1 got %h exp 0", rd1_out); end
    n_chk++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL reset_stall got %0d exp 0", stall_count); end
    n_chk++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready_during got %b exp 0", ready_out); end
    RESET = 1'b0;
    set_in(1'b0, 64'h0, 8'h00);
    #1;
    n_chk++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %b exp 1", ready_out); end
  endtask

  task automatic test_stream();
    reset_dut();
    ready_in = 1'b1;
    set_in(1'b1, 64'h40, 8'hC5);
    step();
    n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL stream_valid0 got %b exp 1", valid_out); end
    n_chk++; if (pc_out !== 64'h40) begin n_fail++; $display("FAIL stream_pc0 got %h exp 40", pc_out); end
    n_chk++; if (ctrl_out !== 8'hC5) begin n_fail++; $display("FAIL stream_ctrl0 got %h exp c5", ctrl_out); end
    n_chk++; if (rd1_out !== 64'hFFFF_0000_FFFF_0040) begin n_fail++; $display("FAIL stream_rd1 got %h exp ffff0000ffff0040", rd1_out); end
    n_chk++; if (rd2_out !== 64'h0000_0040_0000_0000) begin n_fail++; $display("FAIL stream_rd2 got %h exp 0000004000000000", rd2_out); end
    n_chk++; if (sext_out !== 64'h48) begin n_fail++; $display("FAIL stream_sext got %h exp 48", sext_out); end
    n_chk++; if (aluc_out !== 11'h040) begin n_fail++; $display("FAIL stream_aluc got %h exp 040", aluc_out); end
    n_chk++; if ({rm_out, rn_out, wr_out} !== {5'h1F, 5'h10, 5'h08}) begin n_fail++; $display("FAIL stream_regs got %h/%h/%h exp 1f/10/08", rm_out, rn_out, wr_out); end
    set_in(1'b1, 64'h44, 8'h15);
    step();
    n_chk++; if (valid_out !== 1'b1 || pc_out !== 64'h44) begin n_fail++; $display("FAIL stream_pc1 got v=%b %h exp v=1 44", valid_out, pc_out); end
    n_chk++; if (ctrl_out !== 8'h15) begin n_fail++; $display("FAIL stream_ctrl1 got %h exp 15", ctrl_out); end
    set_in(1'b1, 64'h48, 8'h81);
    step();
    n_chk++; if (valid_out !== 1'b1 || pc_out !== 64'h48) begin n_fail++; $display("FAIL stream_pc2 got v=%b %h exp v=1 48", valid_out, pc_out); end
    set_in(1'b0, 64'h99, 8'hFF);
    step();
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid got %b exp 0", valid_out); end
    n_chk++; if (ctrl_out !== 8'h00) begin n_fail++; $display("FAIL stream_bubble_ctrl got %h exp 00", ctrl_out); end
    n_chk++; if (pc_out !== 64'h48) begin n_fail++; $display("FAIL stream_hold_pc got %h exp 48", pc_out); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    ready_in = 1'b0;
    set_in(1'b1, 64'h40, 8'hC5);
    step();
    n_chk++; if (valid_out !== 1'b1 || pc_out !== 64'h40) begin n_fail++; $display("FAIL bp_first got v=%b %h exp v=1 40", valid_out, pc_out); end
    n_chk++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL bp_stall0 got %0d exp 0", stall_count); end
`ifdef IDEX_SKID_EN
    n_chk++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one got %b exp 1", ready_out); end
`else
    n_chk++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL bp_ready_same_cycle got %b exp 0", ready_out); end
`endif
    set_in(1'b1, 64'h44, 8'h15);
    step();
    n_chk++; if (pc_out !== 64'h40 || valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_hold1 got v=%b %h exp v=1 40", valid_out, pc_out); end
    n_chk++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %b exp 0", ready_out); end
    n_chk++; if (stall_count !== 32'd1) begin n_fail++; $display("FAIL bp_stall1 got %0d exp 1", stall_count); end
`ifdef IDEX_SKID_EN
    valid_in = 1'b0;
`endif
    step();
    n_chk++; if (pc_out !== 64'h40) begin n_fail++; $display("FAIL bp_hold2 got %h exp 40", pc_out); end
    n_chk++; if (stall_count !== 32'd2) begin n_fail++; $display("FAIL bp_stall2 got %0d exp 2", stall_count); end
    ready_in = 1'b1;
    step();
    n_chk++; if (valid_out !== 1'b1 || pc_out !== 64'h44) begin n_fail++; $display("FAIL bp_second got v=%b %h exp v=1 44", valid_out, pc_out); end
    n_chk++; if (ctrl_out !== 8'h15) begin n_fail++; $display("FAIL bp_second_ctrl got %h exp 15", ctrl_out); end
    n_chk++; if (stall_count !== 32'd2) begin n_fail++; $display("FAIL bp_stall_frozen got %0d exp 2", stall_count); end
    valid_in = 1'b0;
    step();
    n_chk++; if (valid_out !== 1'b0 || ctrl_out !== 8'h00) begin n_fail++; $display("FAIL bp_drained got v=%b ctrl=%h exp v=0 ctrl=00", valid_out, ctrl_out); end
  endtask

  task automatic test_flush();
    reset_dut();
    ready_in = 1'b0;
    set_in(1'b1, 64'h40, 8'hC5);
    step();
    set_in(1'b1, 64'h44, 8'h15);
    step();
    set_in(1'b1, 64'h48, 8'hFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", valid_out); end
    n_chk++; if (ctrl_out !== 8'h00) begin n_fail++; $display("FAIL flush_ctrl got %h exp 00", ctrl_out); end
    n_chk++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b exp 1", ready_out); end
    n_chk++; if (stall_count !== 32'd1) begin n_fail++; $display("FAIL flush_stall got %0d exp 1", stall_count); end
    valid_in = 1'b0;
    ready_in = 1'b1;
    step();
    step();
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_no_revive got %b exp 0", valid_out); end
    n_chk++; if (pc_out !== 64'h40) begin n_fail++; $display("FAIL flush_pc_held got %h exp 40", pc_out); end
    set_in(1'b1, 64'h4C, 8'hA3);
    step();
    n_chk++; if (valid_out !== 1'b1 || pc_out !== 64'h4C || ctrl_out !== 8'hA3) begin n_fail++; $display("FAIL flush_resume got v=%b %h ctrl=%h exp v=1 4c a3", valid_out, pc_out, ctrl_out); end
    valid_in = 1'b0;
    step();
  endtask

  task automatic test_reset_midstream();
    reset_dut();
    ready_in = 1'b0;
    set_in(1'b1, 64'h40, 8'hC5);
    step();
    set_in(1'b1, 64'h44, 8'h15);
    step();
    step();
    n_chk++; if (stall_count !== 32'd2) begin n_fail++; $display("FAIL rmid_pre_stall got %0d exp 2", stall_count); end
    RESET = 1'b1;
    step();
    n_chk++; if (valid_out !== 1'b0 || ctrl_out !== 8'h00 || pc_out !== 64'h0) begin n_fail++; $display("FAIL rmid_cleared got v=%b ctrl=%h pc=%h exp 0", valid_out, ctrl_out, pc_out); end
    n_chk++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL rmid_stall got %0d exp 0", stall_count); end
    n_chk++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL rmid_ready got %b exp 0", ready_out); end
    RESET = 1'b0;
    ready_in = 1'b1;
    set_in(1'b1, 64'h100, 8'h3A);
    step();
    n_chk++; if (valid_out !== 1'b1 || pc_out !== 64'h100 || ctrl_out !== 8'h3A) begin n_fail++; $display("FAIL rmid_first got v=%b %h ctrl=%h exp v=1 100 3a", valid_out, pc_out, ctrl_out); end
    valid_in = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    reset_dut();
    ready_in = 1'b0;
    set_in(1'b1, 64'h40, 8'hC5);
    step();
    valid_in = 1'b0;
    repeat (15) step();
    n_chk++; if (stall_count4 !== 4'hF) begin n_fail++; $display("FAIL sat_reach got %h exp f", stall_count4); end
    n_chk++; if (stall_count !== 32'd15) begin n_fail++; $display("FAIL sat_wide15 got %0d exp 15", stall_count); end
    repeat (5) step();
    n_chk++; if (stall_count4 !== 4'hF) begin n_fail++; $display("FAIL sat_hold20 got %h exp f", stall_count4); end
    n_chk++; if (stall_count !== 32'd20) begin n_fail++; $display("FAIL sat_wide20 got %0d exp 20", stall_count); end
    repeat (3) step();
    n_chk++; if (stall_count4 !== 4'hF) begin n_fail++; $display("FAIL sat_stays got %h exp f", stall_count4); end
    n_chk++; if (stall_count !== 32'd23) begin n_fail++; $display("FAIL sat_wide23 got %0d exp 23", stall_count); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
